// File: rtl/loader_pkg.sv
// Shared state encoding, byte-strobe constants and FIFO word layout for the
// ROM loader write path.
package loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StDrain,
      StClear,
      StRun
   } state_e;

   localparam logic [1:0] DS_LOW  = 2'b01;
   localparam logic [1:0] DS_BOTH = 2'b11;

   typedef struct packed {
      logic [22:0] addr;
      logic [15:0] data;
      logic [1:0]  ds;
   } mem_word_t;

   localparam int unsigned MEM_WORD_W = $bits(mem_word_t);

   function automatic mem_word_t make_word(input logic [22:0] addr,
                                           input logic [15:0] data,
                                           input logic [1:0]  ds);
      mem_word_t w;
      w.addr = addr;
      w.data = data;
      w.ds   = ds;
      return w;
   endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO with synchronous active-low reset and a synchronous
// clear; push while full and pop while empty are ignored.
module word_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 41
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty_o = (wptr_q == rptr_q);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (clr_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push_i && !full_o) begin
            mem_d[wptr_q[AW-1:0]] = wdata_i;
            wptr_d                = wptr_q + 1'b1;
         end
         if (pop_i && !empty_o) begin
            rptr_d = rptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/rom_sdram_writer.sv
// Packs loader ROM bytes into 16-bit SDRAM writes, then zero-fills the save RAM
// and releases the SNES core from reset.
module rom_sdram_writer
   import loader_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [22:0] BSRAM_BASE = 23'h380000
) (
   input  logic        wclk,
   input  logic        resetn,
   input  logic        loading,
   input  logic [7:0]  din,
   input  logic        din_valid,
   input  logic [23:0] ram_mask,
   output logic        mem_req,
   output logic [22:0] mem_addr,
   output logic [15:0] mem_din,
   output logic [1:0]  mem_ds,
   input  logic        mem_ack,
   output logic        snes_reset,
   output logic        overflow,
   output logic [22:0] word_count
);

   state_e      state_q, state_d;
   logic        loading_q;
   logic        have_low_q, have_low_d;
   logic [7:0]  low_q, low_d;
   logic        push_q, push_d;
   logic [15:0] push_data_q, push_data_d;
   logic [1:0]  push_ds_q, push_ds_d;
   logic [22:0] word_count_q, word_count_d;
   logic        overflow_q, overflow_d;
   logic        req_q, req_d;
   logic [22:0] addr_q, addr_d;
   logic [15:0] din_q, din_d;
   logic [1:0]  ds_q, ds_d;
   logic        snes_reset_q, snes_reset_d;
   logic [23:0] mask_q, mask_d;
   logic [22:0] clr_cnt_q, clr_cnt_d;
   logic        abort_q, abort_d;

   logic        rise, fall, ack;
   logic        go_load, issue_fifo, issue_clr;
   logic        fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
   mem_word_t   fifo_wdata, fifo_head;

   assign rise = loading && !loading_q;
   assign fall = !loading && loading_q;
   // Acks only count against an outstanding request.
   assign ack  = mem_ack && req_q;

   assign fifo_wdata = make_word(word_count_q, push_data_q, push_ds_q);

   word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (MEM_WORD_W)
   ) u_word_fifo (
      .clk_i   (wclk),
      .rst_ni  (resetn),
      .clr_i   (fifo_clr),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      have_low_d   = have_low_q;
      low_d        = low_q;
      push_d       = 1'b0;
      push_data_d  = push_data_q;
      push_ds_d    = push_ds_q;
      word_count_d = word_count_q;
      overflow_d   = overflow_q;
      req_d        = req_q;
      addr_d       = addr_q;
      din_d        = din_q;
      ds_d         = ds_q;
      snes_reset_d = snes_reset_q;
      mask_d       = mask_q;
      clr_cnt_d    = clr_cnt_q;
      abort_d      = abort_q;
      go_load      = 1'b0;
      issue_fifo   = 1'b0;
      issue_clr    = 1'b0;
      fifo_push    = 1'b0;
      fifo_pop     = 1'b0;
      fifo_clr     = 1'b0;

      // A completed word is dropped when the FIFO is full but still consumes an address.
      if (push_q) begin
         fifo_push    = !fifo_full;
         overflow_d   = overflow_q | fifo_full;
         word_count_d = word_count_q + 23'd1;
      end

      if (ack) begin
         req_d    = 1'b0;
         fifo_pop = (state_q != StClear);
      end

      unique case (state_q)
         StIdle, StRun: begin
            go_load = rise;
         end

         StLoad: begin
            if (din_valid) begin
               if (have_low_q) begin
                  push_d      = 1'b1;
                  push_data_d = {din, low_q};
                  push_ds_d   = DS_BOTH;
                  have_low_d  = 1'b0;
               end else if (fall) begin
                  push_d      = 1'b1;
                  push_data_d = {8'h00, din};
                  push_ds_d   = DS_LOW;
               end else begin
                  low_d      = din;
                  have_low_d = 1'b1;
               end
            end else if (fall && have_low_q) begin
               push_d      = 1'b1;
               push_data_d = {8'h00, low_q};
               push_ds_d   = DS_LOW;
               have_low_d  = 1'b0;
            end
            if (fall) begin
               state_d = StDrain;
               mask_d  = ram_mask;
            end
            issue_fifo = !req_q && !fifo_empty;
         end

         StDrain: begin
            if (rise || abort_q) begin
               go_load = !req_q || ack;
               abort_d = 1'b1;
            end else if (!req_q) begin
               if (!fifo_empty) begin
                  issue_fifo = 1'b1;
               end else if (!push_q) begin
                  if (mask_q == 24'd0) begin
                     state_d      = StRun;
                     snes_reset_d = 1'b0;
                  end else begin
                     state_d   = StClear;
                     clr_cnt_d = '0;
                  end
               end
            end
         end

         StClear: begin
            if (rise || abort_q) begin
               go_load = !req_q || ack;
               abort_d = 1'b1;
            end else if (ack) begin
               if (clr_cnt_q == mask_q[23:1]) begin
                  state_d      = StRun;
                  snes_reset_d = 1'b0;
               end else begin
                  clr_cnt_d = clr_cnt_q + 23'd1;
               end
            end else if (!req_q) begin
               issue_clr = 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (issue_fifo) begin
         req_d  = 1'b1;
         addr_d = fifo_head.addr;
         din_d  = fifo_head.data;
         ds_d   = fifo_head.ds;
      end

      if (issue_clr) begin
         req_d  = 1'b1;
         addr_d = BSRAM_BASE + clr_cnt_q;
         din_d  = 16'h0000;
         ds_d   = DS_BOTH;
      end

      // Entering LOAD discards everything left over from the previous load.
      if (go_load) begin
         state_d      = StLoad;
         word_count_d = '0;
         overflow_d   = 1'b0;
         have_low_d   = 1'b0;
         push_d       = 1'b0;
         abort_d      = 1'b0;
         snes_reset_d = 1'b1;
         req_d        = 1'b0;
         fifo_clr     = 1'b1;
         fifo_push    = 1'b0;
         fifo_pop     = 1'b0;
      end
   end

   always_ff @(posedge wclk) begin
      if (!resetn) begin
         state_q      <= StIdle;
         loading_q    <= 1'b0;
         have_low_q   <= 1'b0;
         low_q        <= '0;
         push_q       <= 1'b0;
         push_data_q  <= '0;
         push_ds_q    <= '0;
         word_count_q <= '0;
         overflow_q   <= 1'b0;
         req_q        <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
         ds_q         <= '0;
         snes_reset_q <= 1'b1;
         mask_q       <= '0;
         clr_cnt_q    <= '0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         loading_q    <= loading;
         have_low_q   <= have_low_d;
         low_q        <= low_d;
         push_q       <= push_d;
         push_data_q  <= push_data_d;
         push_ds_q    <= push_ds_d;
         word_count_q <= word_count_d;
         overflow_q   <= overflow_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         ds_q         <= ds_d;
         snes_reset_q <= snes_reset_d;
         mask_q       <= mask_d;
         clr_cnt_q    <= clr_cnt_d;
         abort_q      <= abort_d;
      end
   end

   assign mem_req    = req_q;
   assign mem_addr   = addr_q;
   assign mem_din    = din_q;
   assign mem_ds     = ds_q;
   assign snes_reset = snes_reset_q;
   assign overflow   = overflow_q;
   assign word_count = word_count_q;

endmodule

// File: doc/rom_sdram_writer.md
ROM_SDRAM_WRITER -- requirements
Module: rom_sdram_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: word FIFO entries, power of two, 2 to 16.
REQ-002 Parameter BSRAM_BASE, default 23'h380000: word address of the first save-RAM word.
REQ-003 wclk  in  1  clock; all logic on the rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 loading  in  1  loader busy flag; its rising edge starts a load, its falling edge ends it.
REQ-006 din  in  8  ROM byte from the loader.
REQ-007 din_valid  in  1  one-cycle strobe; din is valid while it is high.
REQ-008 ram_mask  in  24  save-RAM byte mask; sampled on the falling edge of loading.
REQ-009 mem_req  out  1  memory write request.
REQ-010 mem_addr  out  23  word address.
REQ-011 mem_din  out  16  write data.
REQ-012 mem_ds  out  2  byte strobes; bit0 is the low (even) byte.
REQ-013 mem_ack  in  1  one-cycle completion pulse.
REQ-014 snes_reset  out  1  holds the SNES core in reset.
REQ-015 overflow  out  1  sticky flag: a byte was dropped.
REQ-016 word_count  out  23  number of ROM words accepted in the current load.

Function
REQ-017 States SHALL be IDLE, LOAD, DRAIN, CLEAR and RUN.
REQ-018 IDLE or RUN SHALL go to LOAD on a loading rising edge; entry clears word_count, overflow, the FIFO and the pack register, and sets snes_reset=1.
REQ-019 In LOAD, an even-ordinal byte SHALL be held in the pack register as the low byte.
REQ-020 In LOAD, an odd-ordinal byte SHALL complete the word {din, low} with ds=2'b11 at word address word_count; it is pushed to the FIFO one cycle after its din_valid, and word_count then increments.
REQ-021 If the FIFO is full when a word must be pushed, the word SHALL be dropped, overflow set to 1 and word_count still incremented, so addresses stay aligned.
REQ-022 If the FIFO is not empty and no request is outstanding, mem_req SHALL rise the next cycle from the FIFO head.
REQ-023 mem_req, mem_addr, mem_din and mem_ds SHALL stay stable until mem_ack; the FIFO pops on mem_ack; mem_req drops in the cycle after mem_ack.
REQ-024 A mem_ack received while mem_req is low SHALL be ignored.
REQ-025 A loading falling edge in LOAD SHALL move to DRAIN; a pending odd byte is pushed as {8'h00, low} with ds=2'b01.
REQ-026 DRAIN SHALL move to CLEAR once the FIFO is empty and no request is outstanding.
REQ-027 CLEAR SHALL write 16'h0000 with ds=2'b11 to BSRAM_BASE+0 up to BSRAM_BASE+ram_mask[23:1], one request at a time; the word counter wraps inside 23 bits.
REQ-028 When ram_mask==0, CLEAR SHALL be skipped (DRAIN goes straight to RUN).
REQ-029 Completion of the last clear word SHALL move to RUN, with snes_reset=0 in the following cycle.
REQ-030 A loading rising edge in DRAIN or CLEAR SHALL abort: the outstanding request completes, then the block enters LOAD per REQ-018.
REQ-031 In IDLE and RUN, din_valid SHALL be ignored.
REQ-032 A din_valid in the same cycle as a loading rising edge SHALL be dropped.
REQ-033 A din_valid in the same cycle as a loading falling edge SHALL be accepted before the transition to DRAIN.

Reset
REQ-034 Reset SHALL force state=IDLE, mem_req=0, mem_addr=0, mem_din=0, mem_ds=0, snes_reset=1, overflow=0 and word_count=0, and empty the FIFO.
REQ-035 Reset SHALL override any outstanding handshake; a later mem_ack is ignored per REQ-024.

Structure
REQ-036 The state encoding and the DS_LOW/DS_BOTH constants SHALL live in a shared package, loader_pkg.
REQ-037 The word FIFO SHALL be the sub-module word_fifo (data 41 bits = addr+data+ds, FIFO_DEPTH entries, synchronous reset, full/empty outputs).

Verification
REQ-038 Load bytes 11,22,33,44 then drop loading, ram_mask=0 -> writes (0,16'h2211,11),(1,16'h4433,11); RUN; snes_reset=0.
REQ-039 Load 3 bytes AA,BB,CC, ram_mask=0 -> second write is (1,16'h00CC,01).
REQ-040 Hold mem_ack low while 6 words stream in with FIFO_DEPTH=4 -> overflow=1, word_count=6, and the addresses of later words are unshifted.
REQ-041 Load 2 bytes with ram_mask=24'h7FF -> 1024 zero writes at 23'h380000 to 23'h3803FF, then RUN.
REQ-042 Raise loading during CLEAR with a request outstanding -> the request completes on ack, the state goes to LOAD, word_count=0 and snes_reset stays 1.
REQ-043 Assert resetn=0 mid-handshake, then pulse mem_ack -> IDLE, mem_req=0, and no FIFO pop.
